countdown_timer: RTL and testbench

- Consumes the two-digit BCD time value produced by the add/sub digit-setting logic and counts it down to zero at a fixed tick rate.
- Provides start, pause and cancel control, a live remaining-time output for the display path, a one-cycle done pulse and a timed alarm.
- Sits between the time-setting front end and the display/alarm drivers.

---
 rtl/timer_pkg.sv | 14 +
 rtl/tick_prescaler.sv | 28 ++
 rtl/countdown_timer.sv | 118 +++++++++++
 tb/tb_countdown_timer.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// Shared types and BCD helpers for the countdown timer.
package timer_pkg;

  typedef enum logic [1:0] {IDLE, RUN, PAUSED, DONE} state_t;

  typedef logic [3:0] bcd_t;

  localparam bcd_t BCD_MAX = 4'd9;

  function automatic bcd_t bcd_clamp(input bcd_t d);
    return (d > BCD_MAX) ? BCD_MAX : d;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides clk down to a one-cycle tick every TICK_DIV enabled cycles.
module tick_prescaler #(
  parameter int TICK_DIV = 50000000
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      count <= '0;
    end else if (en) begin
      count <= (count == LAST) ? '0 : count + CNT_W'(1);
    end
  end

  // The count only holds while en is low, so pause freezes the phase.
  assign tick = en && (count == LAST);

endmodule

// File: rtl/countdown_timer.sv
// Two-digit BCD countdown with start/pause/cancel, expiry pulse and timed alarm.
module countdown_timer
  import timer_pkg::*;
#(
  parameter int TICK_DIV    = 50000000,
  parameter int ALARM_TICKS = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] set_value,
  input  logic       start,
  input  logic       pause,
  input  logic       cancel,
  output logic [7:0] remaining,
  output logic       running,
  output logic       done,
  output logic       alarm
);

  localparam int AL_W = $clog2(ALARM_TICKS + 1);
  localparam logic [AL_W-1:0] AL_LAST = AL_W'(ALARM_TICKS - 1);

  state_t          state;
  logic [AL_W-1:0] al_cnt;
  logic [7:0]      load_val;
  logic            load_ok;
  logic            tick;
  logic            en;
  logic            clr;

  function automatic logic [7:0] bcd_dec(input logic [7:0] v);
    if (v[3:0] == 4'd0) begin
      return {v[7:4] - 4'd1, BCD_MAX};
    end
    return {v[7:4], v[3:0] - 4'd1};
  endfunction

  assign load_val = {bcd_clamp(set_value[7:4]), bcd_clamp(set_value[3:0])};
  assign load_ok  = start && !cancel && (load_val != 8'h00) &&
                    ((state == IDLE) || (state == DONE));

  // Pause gates the enable in the same cycle so a pending tick is held back.
  assign en  = ((state == RUN) && !pause) || (state == DONE);
  assign clr = load_ok || cancel;

  tick_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .en    (en),
    .clr   (clr),
    .tick  (tick)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      remaining <= 8'h00;
      done      <= 1'b0;
      al_cnt    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (load_ok) begin
            state     <= RUN;
            remaining <= load_val;
          end
        end
        RUN: begin
          if (cancel) begin
            state     <= IDLE;
            remaining <= 8'h00;
          end else if (pause) begin
            state <= PAUSED;
          end else if (tick) begin
            if (remaining == 8'h01) begin
              state     <= DONE;
              remaining <= 8'h00;
              done      <= 1'b1;
              al_cnt    <= '0;
            end else begin
              remaining <= bcd_dec(remaining);
            end
          end
        end
        PAUSED: begin
          if (cancel) begin
            state     <= IDLE;
            remaining <= 8'h00;
          end else if (start) begin
            state <= RUN;
          end
        end
        DONE: begin
          if (cancel) begin
            state <= IDLE;
          end else if (load_ok) begin
            state     <= RUN;
            remaining <= load_val;
          end else if (tick) begin
            if (al_cnt == AL_LAST) begin
              state <= IDLE;
            end else begin
              al_cnt <= al_cnt + AL_W'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign running = (state == RUN);
  assign alarm   = (state == DONE);

endmodule

// File: tb/tb_countdown_timer.sv
// Scenario bench for countdown_timer with TICK_DIV=4, ALARM_TICKS=2.
module tb_countdown_timer;

  localparam int TICK_DIV    = 4;
  localparam int ALARM_TICKS = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] set_value;
  logic       start;
  logic       pause;
  logic       cancel;
  logic [7:0] remaining;
  logic       running;
  logic       done;
  logic       alarm;

  int         pass_cnt  = 0;
  int         total_cnt = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_v;

  countdown_timer #(
    .TICK_DIV    (TICK_DIV),
    .ALARM_TICKS (ALARM_TICKS)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .set_value (set_value),
    .start     (start),
    .pause     (pause),
    .cancel    (cancel),
    .remaining (remaining),
    .running   (running),
    .done      (done),
    .alarm     (alarm)
  );

  always #5 clk = ~clk;

  // Called at a negedge; the following posedge samples the pulse.
  task automatic drive(input logic st, input logic pa, input logic ca, input logic [7:0] val);
    start     = st;
    pause     = pa;
    cancel    = ca;
    set_value = val;
    @(negedge clk);
    start  = 1'b0;
    pause  = 1'b0;
    cancel = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    total_cnt++; if (remaining !== 8'h00) $display("FAIL reset_remaining got=%h exp=%h", remaining, 8'h00); else pass_cnt++;
    total_cnt++; if (running !== 1'b0) $display("FAIL reset_running got=%b exp=0", running); else pass_cnt++;
    total_cnt++; if (done !== 1'b0) $display("FAIL reset_done got=%b exp=0", done); else pass_cnt++;
    total_cnt++; if (alarm !== 1'b0) $display("FAIL reset_alarm got=%b exp=0", alarm); else pass_cnt++;
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic;
    int hi;
    exp_q.push_back(8'h03); exp_q.push_back(8'h02); exp_q.push_back(8'h01); exp_q.push_back(8'h00);
    drive(1'b1, 1'b0, 1'b0, 8'h03);
    exp_v = exp_q.pop_front();
    total_cnt++; if (remaining !== exp_v) $display("FAIL basic_load got=%h exp=%h", remaining, exp_v); else pass_cnt++;
    total_cnt++; if (running !== 1'b1) $display("FAIL basic_running got=%b exp=1", running); else pass_cnt++;
    for (int i = 1; i < 4; i++) begin
      repeat (3) @(negedge clk);
      total_cnt++; if (remaining === exp_q[0]) $display("FAIL basic_early_step%0d got=%h before tick", i, remaining); else pass_cnt++;
      total_cnt++; if (done !== 1'b0) $display("FAIL basic_done_early%0d got=%b exp=0", i, done); else pass_cnt++;
      @(negedge clk);
      exp_v = exp_q.pop_front();
      total_cnt++; if (remaining !== exp_v) $display("FAIL basic_step%0d got=%h exp=%h", i, remaining, exp_v); else pass_cnt++;
    end
    total_cnt++; if (done !== 1'b1) $display("FAIL basic_done_pulse got=%b exp=1", done); else pass_cnt++;
    total_cnt++; if (alarm !== 1'b1) $display("FAIL basic_alarm_on got=%b exp=1", alarm); else pass_cnt++;
    total_cnt++; if (running !== 1'b0) $display("FAIL basic_running_done got=%b exp=0", running); else pass_cnt++;
    hi = 1;
    @(negedge clk);
    total_cnt++; if (done !== 1'b0) $display("FAIL basic_done_width got=%b exp=0", done); else pass_cnt++;
    while (alarm && hi < 50) begin
      hi++;
      @(negedge clk);
    end
    total_cnt++; if (hi !== 8) $display("FAIL basic_alarm_len got=%0d exp=8", hi); else pass_cnt++;
    total_cnt++; if (alarm !== 1'b0 || running !== 1'b0) $display("FAIL basic_idle alarm=%b running=%b exp=0/0", alarm, running); else pass_cnt++;
  endtask

  task automatic test_borrow_clamp;
    exp_q.push_back(8'h10);
    drive(1'b1, 1'b0, 1'b0, 8'h10);
    exp_v = exp_q.pop_front();
    total_cnt++; if (remaining !== exp_v) $display("FAIL borrow_load got=%h exp=%h", remaining, exp_v); else pass_cnt++;
    exp_q.push_back(8'h09);
    repeat (4) @(negedge clk);
    exp_v = exp_q.pop_front();
    total_cnt++; if (remaining !== exp_v) $display("FAIL borrow_step got=%h exp=%h", remaining, exp_v); else pass_cnt++;
    exp_q.push_back(8'h00);
    drive(1'b0, 1'b0, 1'b1, 8'h00);
    exp_v = exp_q.pop_front();
    total_cnt++; if (remaining !== exp_v || running !== 1'b0) $display("FAIL cancel_run got=%h/%b exp=%h/0", remaining, running, exp_v); else pass_cnt++;
    exp_q.push_back(8'h99);
    drive(1'b1, 1'b0, 1'b0, 8'hAF);
    exp_v = exp_q.pop_front();
    total_cnt++; if (remaining !== exp_v) $display("FAIL clamp_af got=%h exp=%h", remaining, exp_v); else pass_cnt++;
    drive(1'b0, 1'b0, 1'b1, 8'h00);
    exp_q.push_back(8'h93);
    drive(1'b1, 1'b0, 1'b0, 8'hA3);
    exp_v = exp_q.pop_front();
    total_cnt++; if (remaining !== exp_v) $display("FAIL clamp_a3 got=%h exp=%h", remaining, exp_v); else pass_cnt++;
    drive(1'b0, 1'b0, 1'b1, 8'h00);
  endtask

  task automatic test_pause_resume;
    drive(1'b1, 1'b0, 1'b0, 8'h05);
    repeat (2) @(negedge clk);
    drive(1'b0, 1'b1, 1'b0, 8'h05);
    total_cnt++; if (running !== 1'b0) $display("FAIL pause_running got=%b exp=0", running); else pass_cnt++;
    exp_q.push_back(8'h05);
    repeat (20) @(negedge clk);
    exp_v = exp_q.pop_front();
    total_cnt++; if (remaining !== exp_v || alarm !== 1'b0) $display("FAIL pause_hold got=%h/%b exp=%h/0", remaining, alarm, exp_v); else pass_cnt++;
    exp_q.push_back(8'h05); exp_q.push_back(8'h05); exp_q.push_back(8'h04);
    drive(1'b1, 1'b0, 1'b0, 8'h09);
    exp_v = exp_q.pop_front();
    total_cnt++; if (running !== 1'b1 || remaining !== exp_v) $display("FAIL resume_noreload got=%h/%b exp=%h/1", remaining, running, exp_v); else pass_cnt++;
    @(negedge clk);
    exp_v = exp_q.pop_front();
    total_cnt++; if (remaining !== exp_v) $display("FAIL resume_plus1 got=%h exp=%h", remaining, exp_v); else pass_cnt++;
    @(negedge clk);
    exp_v = exp_q.pop_front();
    total_cnt++; if (remaining !== exp_v) $display("FAIL resume_plus2 got=%h exp=%h", remaining, exp_v); else pass_cnt++;
    drive(1'b0, 1'b0, 1'b1, 8'h00);
  endtask

  task automatic test_collisions;
    exp_q.push_back(8'h00);
    drive(1'b1, 1'b0, 1'b1, 8'h05);
    exp_v = exp_q.pop_front();
    total_cnt++; if (running !== 1'b0 || remaining !== exp_v) $display("FAIL start_cancel got=%h/%b exp=%h/0", remaining, running, exp_v); else pass_cnt++;
    drive(1'b1, 1'b0, 1'b0, 8'h05);
    exp_q.push_back(8'h05);
    drive(1'b1, 1'b1, 1'b0, 8'h05);
    exp_v = exp_q.pop_front();
    total_cnt++; if (running !== 1'b0 || remaining !== exp_v) $display("FAIL start_pause got=%h/%b exp=%h/0", remaining, running, exp_v); else pass_cnt++;
    exp_q.push_back(8'h05);
    repeat (8) @(negedge clk);
    exp_v = exp_q.pop_front();
    total_cnt++; if (remaining !== exp_v) $display("FAIL start_pause_hold got=%h exp=%h", remaining, exp_v); else pass_cnt++;
    exp_q.push_back(8'h00);
    drive(1'b0, 1'b0, 1'b1, 8'h00);
    exp_v = exp_q.pop_front();
    total_cnt++; if (remaining !== exp_v || running !== 1'b0) $display("FAIL cancel_paused got=%h/%b exp=%h/0", remaining, running, exp_v); else pass_cnt++;
  endtask

  task automatic test_zero_and_start_in_run;
    drive(1'b1, 1'b0, 1'b0, 8'h00);
    total_cnt++; if (running !== 1'b0 || remaining !== 8'h00) $display("FAIL zero_start got=%h/%b exp=00/0", remaining, running); else pass_cnt++;
    repeat (4) @(negedge clk);
    total_cnt++; if (done !== 1'b0 || alarm !== 1'b0) $display("FAIL zero_quiet done=%b alarm=%b exp=0/0", done, alarm); else pass_cnt++;
    drive(1'b1, 1'b0, 1'b0, 8'h07);
    @(negedge clk);
    exp_q.push_back(8'h07); exp_q.push_back(8'h07); exp_q.push_back(8'h06);
    drive(1'b1, 1'b0, 1'b0, 8'h03);
    exp_v = exp_q.pop_front();
    total_cnt++; if (running !== 1'b1 || remaining !== exp_v) $display("FAIL start_in_run got=%h/%b exp=%h/1", remaining, running, exp_v); else pass_cnt++;
    @(negedge clk);
    exp_v = exp_q.pop_front();
    total_cnt++; if (remaining !== exp_v) $display("FAIL start_in_run_hold got=%h exp=%h", remaining, exp_v); else pass_cnt++;
    @(negedge clk);
    exp_v = exp_q.pop_front();
    total_cnt++; if (remaining !== exp_v) $display("FAIL start_in_run_tick got=%h exp=%h", remaining, exp_v); else pass_cnt++;
    drive(1'b0, 1'b0, 1'b1, 8'h00);
  endtask

  task automatic test_reset_mid_run;
    drive(1'b1, 1'b0, 1'b0, 8'h42);
    repeat (2) @(negedge clk);
    total_cnt++; if (remaining !== 8'h42 || running !== 1'b1) $display("FAIL pre_reset got=%h/%b exp=42/1", remaining, running); else pass_cnt++;
    reset = 1'b1;
    start = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    start = 1'b0;
    total_cnt++; if (remaining !== 8'h00) $display("FAIL midrst_remaining got=%h exp=00", remaining); else pass_cnt++;
    total_cnt++; if (running !== 1'b0 || done !== 1'b0 || alarm !== 1'b0) $display("FAIL midrst_flags got=%b%b%b exp=000", running, done, alarm); else pass_cnt++;
    repeat (5) @(negedge clk);
    total_cnt++; if (remaining !== 8'h00 || running !== 1'b0) $display("FAIL midrst_stays got=%h/%b exp=00/0", remaining, running); else pass_cnt++;
  endtask

  task automatic test_done_restart;
    drive(1'b1, 1'b0, 1'b0, 8'h01);
    repeat (4) @(negedge clk);
    total_cnt++; if (done !== 1'b1 || alarm !== 1'b1 || remaining !== 8'h00) $display("FAIL one_expiry got=%b%b/%h exp=11/00", done, alarm, remaining); else pass_cnt++;
    @(negedge clk);
    exp_q.push_back(8'h02);
    drive(1'b1, 1'b0, 1'b0, 8'h02);
    exp_v = exp_q.pop_front();
    total_cnt++; if (alarm !== 1'b0 || running !== 1'b1) $display("FAIL done_restart alarm=%b running=%b exp=0/1", alarm, running); else pass_cnt++;
    total_cnt++; if (remaining !== exp_v) $display("FAIL done_restart_val got=%h exp=%h", remaining, exp_v); else pass_cnt++;
    exp_q.push_back(8'h01); exp_q.push_back(8'h00);
    repeat (4) @(negedge clk);
    exp_v = exp_q.pop_front();
    total_cnt++; if (remaining !== exp_v) $display("FAIL restart_step got=%h exp=%h", remaining, exp_v); else pass_cnt++;
    repeat (4) @(negedge clk);
    exp_v = exp_q.pop_front();
    total_cnt++; if (remaining !== exp_v || done !== 1'b1) $display("FAIL restart_expiry got=%h/%b exp=%h/1", remaining, done, exp_v); else pass_cnt++;
    drive(1'b0, 1'b1, 1'b0, 8'h00);
    total_cnt++; if (alarm !== 1'b1) $display("FAIL pause_in_done alarm=%b exp=1", alarm); else pass_cnt++;
    drive(1'b0, 1'b0, 1'b1, 8'h00);
    total_cnt++; if (alarm !== 1'b0 || running !== 1'b0) $display("FAIL cancel_done alarm=%b running=%b exp=0/0", alarm, running); else pass_cnt++;
  endtask

  initial begin
    reset     = 1'b1;
    start     = 1'b0;
    pause     = 1'b0;
    cancel    = 1'b0;
    set_value = 8'h00;
    test_reset;
    test_basic;
    test_borrow_clamp;
    test_pause_resume;
    test_collisions;
    test_zero_and_start_in_run;
    test_reset_mid_run;
    test_done_restart;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
